// File: rtl/strait_pkg.sv
// Shared definitions for the fault-tolerant systolic mapping blocks:
// mapping FSM states, default array size and the row-index width helper.
package strait_pkg;

    localparam int SYSTOLIC_SIZE_DEFAULT = 8;

    // state        | meaning
    // ST_IDLE      | after reset, waiting for start
    // ST_WAIT_W    | ready for next weight row
    // ST_ISSUE     | one-cycle allocation request to storage
    // ST_WAIT_RES  | sampling storage match result
    // ST_STEP4     | fallback: lowest unused fault-free physical row
    // ST_DONE      | pass finished, map stable until next start
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_W,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_STEP4,
        ST_DONE
    } row_map_state_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/free_row_picker.sv
// Lowest-set-bit priority encoder: returns the index of the lowest request
// bit and whether any bit was set.
module free_row_picker #(
    parameter int WIDTH = 8,
    parameter int IDX_W = strait_pkg::addr_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/row_mapping_table.sv
// Row mapping controller: feeds weight rows to faulty-PE storage and builds the
// logical-to-physical row map, falling back to the lowest free fault-free row.
module row_mapping_table
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEFAULT,
    parameter int ADDR_WIDTH    = addr_width(SYSTOLIC_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            w_valid,
    output logic                            w_ready,
    input  logic [SYSTOLIC_SIZE-1:0]        w_zero_flags,
    output logic                            alloc_valid,
    output logic [SYSTOLIC_SIZE-1:0]        alloc_zero_flags,
    output logic [ADDR_WIDTH-1:0]           alloc_row_addr,
    input  logic                            match_success,
    input  logic                            match_failed,
    input  logic [ADDR_WIDTH-1:0]           faulty_row_addr,
    input  logic [SYSTOLIC_SIZE-1:0]        faulty_rows_mask,
    input  logic                            all_faulty_matched,
    output logic [SYSTOLIC_SIZE*ADDR_WIDTH-1:0] map_phys_flat,
    output logic [SYSTOLIC_SIZE-1:0]        map_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            recovery_fail,
    output logic [ADDR_WIDTH-1:0]           fail_row,
    output logic                            unmatched_faults,
    input  logic [ADDR_WIDTH-1:0]           lookup_logical,
    output logic [ADDR_WIDTH-1:0]           lookup_phys,
    output logic                            lookup_valid
);

    row_map_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]    row_q, row_d;
    logic [SYSTOLIC_SIZE-1:0] flags_q, flags_d;
    logic [SYSTOLIC_SIZE-1:0] snap_q, snap_d;
    logic [SYSTOLIC_SIZE-1:0] used_q, used_d;
    logic [SYSTOLIC_SIZE-1:0] mvalid_q, mvalid_d;
    logic [ADDR_WIDTH-1:0]    map_q [SYSTOLIC_SIZE];
    logic [ADDR_WIDTH-1:0]    map_d [SYSTOLIC_SIZE];
    logic                     rfail_q, rfail_d;
    logic [ADDR_WIDTH-1:0]    frow_q, frow_d;
    logic                     unm_q, unm_d;

    logic                     last_row;
    logic [SYSTOLIC_SIZE-1:0] cand;
    logic [ADDR_WIDTH-1:0]    pick_idx;
    logic                     pick_found;
    logic                     wr_en;
    logic [ADDR_WIDTH-1:0]    wr_phys;
    row_map_state_t           adv_state;

    assign last_row  = (row_q == ADDR_WIDTH'(SYSTOLIC_SIZE - 1));
    assign cand      = ~snap_q & ~used_q;
    assign adv_state = last_row ? ST_DONE : ST_WAIT_W;

    free_row_picker #(
        .WIDTH (SYSTOLIC_SIZE),
        .IDX_W (ADDR_WIDTH)
    ) u_picker (
        .req_i   (cand),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A missing storage result is treated exactly like match_failed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_WAIT_W;
            ST_WAIT_W:        if (w_valid) state_d = ST_ISSUE;
            ST_ISSUE:         state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (match_success) begin
                    state_d = adv_state;
                end else if (match_failed || !match_success) begin
                    state_d = ST_STEP4;
                end
            end
            ST_STEP4:         state_d = pick_found ? adv_state : ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready     = 1'b0;
        alloc_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_WAIT_W: begin
                w_ready = 1'b1;
                busy    = 1'b1;
            end
            ST_ISSUE: begin
                alloc_valid = 1'b1;
                busy        = 1'b1;
            end
            ST_WAIT_RES, ST_STEP4: busy = 1'b1;
            ST_DONE:               done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        row_d    = row_q;
        flags_d  = flags_q;
        snap_d   = snap_q;
        used_d   = used_q;
        mvalid_d = mvalid_q;
        map_d    = map_q;
        rfail_d  = rfail_q;
        frow_d   = frow_q;
        unm_d    = unm_q;
        wr_en    = 1'b0;
        wr_phys  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mvalid_d = '0;
                    used_d   = '0;
                    rfail_d  = 1'b0;
                    unm_d    = 1'b0;
                    snap_d   = faulty_rows_mask;
                    row_d    = '0;
                end
            end
            ST_WAIT_W: if (w_valid) flags_d = w_zero_flags;
            ST_WAIT_RES: begin
                if (match_success) begin
                    wr_en   = 1'b1;
                    wr_phys = faulty_row_addr;
                end
            end
            ST_STEP4: begin
                if (pick_found) begin
                    wr_en   = 1'b1;
                    wr_phys = pick_idx;
                end else begin
                    rfail_d = 1'b1;
                    frow_d  = row_q;
                end
            end
            default: ;
        endcase
        if (wr_en) begin
            map_d[row_q]    = wr_phys;
            mvalid_d[row_q] = 1'b1;
            used_d[wr_phys] = 1'b1;
            if (!last_row) row_d = row_q + 1'b1;
        end
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            unm_d = ~all_faulty_matched;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            flags_q  <= '0;
            snap_q   <= '0;
            used_q   <= '0;
            mvalid_q <= '0;
            map_q    <= '{default: '0};
            rfail_q  <= 1'b0;
            frow_q   <= '0;
            unm_q    <= 1'b0;
        end else begin
            row_q    <= row_d;
            flags_q  <= flags_d;
            snap_q   <= snap_d;
            used_q   <= used_d;
            mvalid_q <= mvalid_d;
            map_q    <= map_d;
            rfail_q  <= rfail_d;
            frow_q   <= frow_d;
            unm_q    <= unm_d;
        end
    end

    for (genvar k = 0; k < SYSTOLIC_SIZE; k++) begin : g_flat
        assign map_phys_flat[k*ADDR_WIDTH +: ADDR_WIDTH] = map_q[k];
    end

    assign alloc_zero_flags = flags_q;
    assign alloc_row_addr   = row_q;
    assign map_valid        = mvalid_q;
    assign recovery_fail    = rfail_q;
    assign fail_row         = frow_q;
    assign unmatched_faults = unm_q;
    assign lookup_phys      = map_q[lookup_logical];
    assign lookup_valid     = mvalid_q[lookup_logical];

endmodule

// File: doc/row_mapping_table.md
Name: row_mapping_table

Overview:
- Downstream and control partner of the faulty-PE storage stage.
- Accepts one weight row at a time from zero-weight detection and issues it to the storage as an allocation request.
- Consumes match_success / match_failed / faulty_row_addr. On a failed match it runs step 4: assign the lowest-index unused fault-free physical row.
- Builds the logical-to-physical row map read by the systolic array's weight loader.

Parameters:
SYSTOLIC_SIZE, 8, array dimension; count of logical rows and of physical rows
ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row index width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin mapping pass; honoured only in IDLE or DONE
w_valid  in  1  weight-row zero flags valid
w_ready  out  1  row accepted when w_valid&w_ready
w_zero_flags  in  SYSTOLIC_SIZE  1 = zero weight in that column
alloc_valid  out  1  one-cycle request to storage (weight_valid)
alloc_zero_flags  out  SYSTOLIC_SIZE  registered copy of accepted flags
alloc_row_addr  out  ADDR_WIDTH  current logical row (current_row_addr)
match_success  in  1  storage result, valid the cycle after alloc_valid
match_failed  in  1  storage result, valid the cycle after alloc_valid
faulty_row_addr  in  ADDR_WIDTH  physical faulty row chosen by storage
faulty_rows_mask  in  SYSTOLIC_SIZE  static faulty-row mask from storage
all_faulty_matched  in  1  storage reports every faulty row consumed
map_phys_flat  out  SYSTOLIC_SIZE*ADDR_WIDTH  entry k = physical row for logical row k
map_valid  out  SYSTOLIC_SIZE  entry k written
busy  out  1  pass in progress
done  out  1  pass finished; held until next start
recovery_fail  out  1  step 4 found no free fault-free row
fail_row  out  ADDR_WIDTH  logical row that failed
unmatched_faults  out  1  at done: ~all_faulty_matched sampled on DONE entry
lookup_logical  in  ADDR_WIDTH  read address
lookup_phys  out  ADDR_WIDTH  combinational map read
lookup_valid  out  1  map_valid[lookup_logical]

Behaviour:
- Reset: state IDLE. Outputs w_ready, alloc_valid, busy, done, recovery_fail, unmatched_faults = 0. fail_row, alloc_row_addr, alloc_zero_flags, map entries, map_valid, used mask = 0.
- FSM: IDLE, WAIT_W, ISSUE, WAIT_RES, STEP4, DONE.
- IDLE/DONE + start:
  - Clear map_valid, used mask, done, recovery_fail, unmatched_faults.
  - Latch faulty_rows_mask into fault_snap; row counter = 0 → WAIT_W.
  - start in other states is ignored.
- WAIT_W: w_ready=1. On handshake, register flags → ISSUE. No timeout; w_valid may idle indefinitely.
- ISSUE: alloc_valid=1 for exactly one cycle, with alloc_row_addr = counter → WAIT_RES.
- WAIT_RES:
  - match_success: map[counter] = faulty_row_addr; set map_valid and used[faulty_row_addr] → advance.
  - match_failed, or neither asserted: → STEP4. Absence of a result is treated as failed.
  - Both asserted: success wins.
- STEP4: candidate = ~fault_snap & ~used.
  - Non-zero: take lowest set index; write map, map_valid and used → advance.
  - Zero: recovery_fail=1, fail_row=counter → DONE. Remaining entries stay invalid.
- Advance: if counter == SYSTOLIC_SIZE-1 → DONE. Else counter+1 → WAIT_W.
- DONE: done=1, busy=0, unmatched_faults latched on entry.
- busy = 1 in WAIT_W..STEP4.
- Latency per row after handshake: success 2 cycles (ISSUE, WAIT_RES); fail 3 cycles.
- A physical row is never mapped twice in one pass. Duplicate faulty_row_addr from storage is not checked; storage guarantees uniqueness via its valid bits.
- Reset mid-pass: immediate return to reset values; no partial map retained.

Decomposition:
- Shared package strait_pkg:
  - state enum (row_map_state_t)
  - ADDR_WIDTH helper function
  - default SYSTOLIC_SIZE constant, shared with faulty_pe_storage
- Sub-module free_row_picker: parameterised lowest-set-bit priority encoder. Outputs index + found. Reused by storage-side tooling.

Test Plan:
- Case 1, no faults: mask=0x00, storage fails all 8 rows → map = 0,1,…,7; all map_valid=0xFF; recovery_fail=0; done 32 cycles after start with w_valid held high.
- Case 2, one fault: mask=0x08, row 3 pattern 0x01, row 0 flags=0x01 → success, map[0]=3. Logical rows 1..7 map to 0,1,2,4,5,6,7; unmatched_faults=0.
- Case 3, all rows faulty: mask=0xFF, no match for row 0 → recovery_fail=1, fail_row=0, map_valid=0x00, done=1 at cycle 4.
- Case 4, backpressure: w_valid toggles 1/0 randomly → w_ready only in WAIT_W; exactly one alloc_valid pulse per accepted row; alloc_row_addr increments 0..7.
- Case 5, reset and restart: assert rst_n low after 3 rows mapped → all outputs at reset values. start then completes a full pass identical to an uninterrupted run.
- Case 6, start while busy: start pulse during WAIT_RES → ignored; counter and map unchanged; pass completes normally.
